serial_transceiver: RTL and testbench
=====================================

Name: serial_transceiver

Overview:
Parallel-to-serial / serial-to-parallel shift engine sitting directly downstream of the read/write flow controller. Consumes the controller's SampleData and TransferData strobes, shifts the captured word out MSB-first on a divided serial clock while capturing SerialIn, and reports completion through TransferDone. TransferDone is the level the controller waits on in its WaitTransferDone state.

Parameters:
DATA_WIDTH, 8, width of the parallel word and number of bits per transfer (>=2)
CLK_DIV, 4, Clk cycles per serial bit; must be even and >=2

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
SampleData  input  1  from controller: capture DataIn into the TX shift register
TransferData  input  1  from controller: start a serial transfer
DataIn  input  DATA_WIDTH  parallel word to transmit (memory read data)
SerialIn  input  1  serial receive line
SerialOut  output  1  serial transmit line, MSB first
SerialClk  output  1  serial bit clock, low in first half of each bit, high in second half
RxData  output  DATA_WIDTH  last fully received word
TransferDone  output  1  level: set at transfer completion, cleared by SampleData
TxBusy  output  1  high while in SHIFT

Behaviour:
- Reset asserted (Reset=0), at any time including mid-transfer: state=IDLE, SerialOut=0, SerialClk=0, RxData=0, TransferDone=0, TxBusy=0, TX/RX shift registers=0, divider and bit counters=0. Takes effect immediately, not on a clock edge.
- States: IDLE, SHIFT.
- IDLE, SampleData=1: TX shift register <= DataIn, TransferDone <= 0 at that edge.
- IDLE, TransferData=1: go to SHIFT next cycle. Transmits current TX register contents; all zeros if nothing was sampled since reset.
- IDLE, both strobes in the same cycle: sample takes effect first. The newly captured DataIn is the word transmitted, and TransferDone clears.
- SHIFT: SampleData and TransferData are ignored, with no effect on any register.
- Timing:
  - TransferData seen at edge T: TxBusy=1 and SerialOut=DataIn[DATA_WIDTH-1] from the cycle after T.
  - Each bit lasts CLK_DIV cycles: SerialClk=0 for the first CLK_DIV/2 cycles and 1 for the last CLK_DIV/2.
  - SerialIn is sampled into the RX shift register (shift left, LSB in) on the first cycle SerialClk is high.
  - SerialOut advances to the next lower bit at the start of each new bit period.
- Divider counter: 0..CLK_DIV-1, wraps to 0. Bit counter increments on each divider wrap.
- Completion: on the divider wrap of bit DATA_WIDTH-1, the block goes to IDLE in the same edge. RxData <= final RX word (including last sampled bit), TransferDone <= 1, TxBusy <= 0, SerialOut <= 0, SerialClk <= 0.
- Transfer length is exactly DATA_WIDTH*CLK_DIV cycles of TxBusy=1.
- TransferDone remains 1 indefinitely until the next SampleData in IDLE, or reset. A TransferData with no intervening SampleData starts a new transfer and leaves TransferDone=1 until completion re-sets it.
- RxData only updates at completion and is stable otherwise.
- All outputs are registered and there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset=0 mid-SHIFT (bit 3 of 8) -> all outputs 0 immediately; after release, TransferDone=0 and IDLE with no spurious activity.
2. DATA_WIDTH=8, CLK_DIV=4; SampleData with DataIn=0xA5, then TransferData -> TxBusy high for exactly 32 cycles; SerialOut bits 1,0,1,0,0,1,0,1, each held 4 cycles; SerialClk pattern 0,0,1,1 per bit; TransferDone=1 on the cycle TxBusy falls.
3. SerialIn looped back from SerialOut with DataIn=0x3C -> RxData=0x3C at completion; RxData unchanged (prior value) during SHIFT.
4. SampleData and TransferData in the same cycle with DataIn=0xF0 -> transmits 0xF0 and TransferDone cleared; SampleData with DataIn=0x11 pulsed during SHIFT -> ignored, remaining bits still from 0xF0.
5. After completion, hold strobes low for 20 cycles -> TransferDone stays 1; then SampleData -> TransferDone=0 on the next cycle.
6. Drive with the flow controller: Active=1, Mode=0, ValidCmd pulse -> controller passes Sample, StartTransfer, WaitTransferDone and returns to Idle exactly one cycle after TransferDone rises; Busy drops accordingly.

Source files
------------

// File: rtl/serial_transceiver.sv
// Parallel-to-serial / serial-to-parallel shift engine fed by the flow controller's
// SampleData/TransferData strobes; shifts MSB-first on a divided bit clock.
module serial_transceiver #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SampleData,
  input  logic                  TransferData,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  SerialIn,
  output logic                  SerialOut,
  output logic                  SerialClk,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  TransferDone,
  output logic                  TxBusy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] txShift;
  logic [DATA_WIDTH-1:0] rxShift;
  logic [DIV_W-1:0]      divCnt;
  logic [BIT_W-1:0]      bitCnt;

  logic                  divWrap;
  logic [DIV_W-1:0]      divNext;
  logic [DATA_WIDTH-1:0] rxNext;
  logic [DATA_WIDTH-1:0] txLoad;

  always_comb begin
    divWrap = (divCnt == DIV_LAST);
    divNext = divWrap ? '0 : divCnt + DIV_W'(1);
    // SerialIn is taken during the first high cycle of SerialClk; at completion
    // this may coincide with the wrap edge, so RxData is loaded from rxNext.
    rxNext  = (divCnt == DIV_HALF) ? {rxShift[DATA_WIDTH-2:0], SerialIn} : rxShift;
    // A same-cycle sample wins, so the fresh word is the one sent.
    txLoad  = SampleData ? DataIn : txShift;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      txShift      <= '0;
      rxShift      <= '0;
      divCnt       <= '0;
      bitCnt       <= '0;
      SerialOut    <= 1'b0;
      SerialClk    <= 1'b0;
      RxData       <= '0;
      TransferDone <= 1'b0;
      TxBusy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SampleData) begin
            txShift      <= DataIn;
            TransferDone <= 1'b0;
          end
          if (TransferData) begin
            state     <= SHIFT;
            TxBusy    <= 1'b1;
            SerialOut <= txLoad[DATA_WIDTH-1];
            SerialClk <= 1'b0;
            divCnt    <= '0;
            bitCnt    <= '0;
            rxShift   <= '0;
          end
        end
        SHIFT: begin
          divCnt    <= divNext;
          rxShift   <= rxNext;
          SerialClk <= (divNext >= DIV_HALF);
          if (divWrap) begin
            // Rotating rather than shifting restores the word after DATA_WIDTH bits.
            txShift <= {txShift[DATA_WIDTH-2:0], txShift[DATA_WIDTH-1]};
            if (bitCnt == BIT_LAST) begin
              state        <= IDLE;
              bitCnt       <= '0;
              RxData       <= rxNext;
              TransferDone <= 1'b1;
              TxBusy       <= 1'b0;
              SerialOut    <= 1'b0;
              SerialClk    <= 1'b0;
            end else begin
              bitCnt    <= bitCnt + BIT_W'(1);
              SerialOut <= txShift[DATA_WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transceiver.sv
// Bench for serial_transceiver: directed strobes, expected words queued at issue time
// and checked by a negedge monitor when a transfer completes.
module tb_serial_transceiver;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic         Clk;
  logic         Reset;
  logic         SampleData;
  logic         TransferData;
  logic [W-1:0] DataIn;
  logic         SerialIn;
  logic         SerialOut;
  logic         SerialClk;
  logic [W-1:0] RxData;
  logic         TransferDone;
  logic         TxBusy;

  logic         loopBack;
  logic         serialDrv;
  logic         ctrlBusy;

  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] expRxHold;

  int checks;
  int failures;

  assign SerialIn = loopBack ? SerialOut : serialDrv;

  serial_transceiver #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SampleData(SampleData),
    .TransferData(TransferData),
    .DataIn(DataIn),
    .SerialIn(SerialIn),
    .SerialOut(SerialOut),
    .SerialClk(SerialClk),
    .RxData(RxData),
    .TransferDone(TransferDone),
    .TxBusy(TxBusy)
  );

  // Clock / watchdog
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: called just after a rising edge, strobe is seen at the next one.
  task automatic strobe(input logic s, input logic t, input logic [W-1:0] d);
    SampleData   = s;
    TransferData = t;
    DataIn       = d;
    @(posedge Clk);
    #1;
    SampleData   = 1'b0;
    TransferData = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] expRx);
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(expRx);
    strobe(1'b1, 1'b0, d);
    strobe(1'b0, 1'b1, 8'h00);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (TxBusy && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, 32'(n < 100), 32'd1);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Flow-controller model: Sample -> StartTransfer -> WaitTransferDone -> Idle.
  task automatic ctrl_command(input logic [W-1:0] d);
    int n;
    ctrlBusy = 1'b1;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(d);
    strobe(1'b1, 1'b0, d);
    strobe(1'b0, 1'b1, 8'h00);
    check("ctrl_wait_entry_done", 32'(TransferDone), 32'd0);
    n = 0;
    while (!TransferDone && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("ctrl_wait_cycles", 32'(n), 32'(W * DIV));
    @(posedge Clk);
    #1;
    ctrlBusy = 1'b0;
    check("ctrl_idle_busy", 32'(TxBusy), 32'd0);
    check("ctrl_idle_done", 32'(TransferDone), 32'd1);
  endtask

  // Scoreboard monitor
  initial begin
    int           busyCnt;
    int           phase;
    logic         prevBusy;
    logic [W-1:0] txCap;
    logic [W-1:0] eTx;
    logic [W-1:0] eRx;
    busyCnt  = 0;
    prevBusy = 1'b0;
    txCap    = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        busyCnt  = 0;
        prevBusy = 1'b0;
      end else begin
        if (TxBusy) begin
          phase = busyCnt % DIV;
          check("serial_clk_phase", 32'(SerialClk), 32'(phase >= DIV / 2));
          if (phase == 0) txCap = {txCap[W-2:0], SerialOut};
          else check("serial_out_hold", 32'(SerialOut), 32'(txCap[0]));
          check("rx_stable_in_shift", 32'(RxData), 32'(expRxHold));
          busyCnt++;
        end else if (prevBusy) begin
          check("done_at_fall", 32'(TransferDone), 32'd1);
          check("busy_length", 32'(busyCnt), 32'(W * DIV));
          check("idle_serial_out", 32'(SerialOut), 32'd0);
          check("idle_serial_clk", 32'(SerialClk), 32'd0);
          if (exp_tx_q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            eTx = exp_tx_q.pop_front();
            eRx = exp_rx_q.pop_front();
            check("tx_word", 32'(txCap), 32'(eTx));
            check("rx_word", 32'(RxData), 32'(eRx));
            expRxHold = eRx;
          end
          busyCnt = 0;
        end
        prevBusy = TxBusy;
      end
    end
  end

  // Stimulus
  initial begin
    checks       = 0;
    failures     = 0;
    Reset        = 1'b0;
    SampleData   = 1'b0;
    TransferData = 1'b0;
    DataIn       = '0;
    loopBack     = 1'b1;
    serialDrv    = 1'b0;
    ctrlBusy     = 1'b0;
    expRxHold    = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_busy", 32'(TxBusy), 32'd0);
    check("reset_done", 32'(TransferDone), 32'd0);
    check("reset_rx", 32'(RxData), 32'd0);
    check("reset_sclk", 32'(SerialClk), 32'd0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // 0xA5 looped back
    send(8'hA5, 8'hA5);
    check("busy_after_start", 32'(TxBusy), 32'd1);
    check("first_bit_msb", 32'(SerialOut), 32'd1);
    wait_idle("idle_a5");

    // Asynchronous reset during bit 3
    send(8'h96, 8'h00);
    void'(exp_tx_q.pop_back());
    void'(exp_rx_q.pop_back());
    repeat (13) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("abort_busy", 32'(TxBusy), 32'd0);
    check("abort_sout", 32'(SerialOut), 32'd0);
    check("abort_sclk", 32'(SerialClk), 32'd0);
    check("abort_rx", 32'(RxData), 32'd0);
    check("abort_done", 32'(TransferDone), 32'd0);
    expRxHold = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("post_abort_busy", 32'(TxBusy), 32'd0);
    check("post_abort_done", 32'(TransferDone), 32'd0);

    // Loopback 0x3C, then driven SerialIn patterns
    send(8'h3C, 8'h3C);
    wait_idle("idle_3c");
    loopBack  = 1'b0;
    serialDrv = 1'b1;
    send(8'h5A, 8'hFF);
    wait_idle("idle_5a");
    serialDrv = 1'b0;
    send(8'hC3, 8'h00);
    wait_idle("idle_c3");
    loopBack  = 1'b1;

    // Simultaneous strobes, then strobes ignored during SHIFT
    check("done_before_both", 32'(TransferDone), 32'd1);
    exp_tx_q.push_back(8'hF0);
    exp_rx_q.push_back(8'hF0);
    strobe(1'b1, 1'b1, 8'hF0);
    check("both_clears_done", 32'(TransferDone), 32'd0);
    repeat (6) @(posedge Clk);
    #1;
    strobe(1'b1, 1'b0, 8'h11);
    strobe(1'b0, 1'b1, 8'h11);
    wait_idle("idle_f0");

    // TransferDone persists until the next sample
    repeat (20) @(posedge Clk);
    #1;
    check("done_held", 32'(TransferDone), 32'd1);
    strobe(1'b1, 1'b0, 8'h77);
    check("sample_clears_done", 32'(TransferDone), 32'd0);
    check("sample_no_busy", 32'(TxBusy), 32'd0);

    // Controller handshake
    ctrl_command(8'h81);
    repeat (3) @(posedge Clk);
    #1;
    check("queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
